// File: rtl/video_stream_pkg.sv
// Shared types and constants for the video source selector and its
// registered output stage.
package video_stream_pkg;

    localparam int PIX_W = 16;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } mux_state_t;

    localparam logic SEL_CAMERA = 1'b0;
    localparam logic SEL_SDCARD = 1'b1;

endpackage

// File: rtl/video_st_out_reg.sv
// Registered Avalon-ST source stage: one beat of storage, ready-latency 0.
// The register reloads whenever it is empty or downstream is taking the
// current beat. With no beat pushed on a reload, valid drops.
module video_st_out_reg
    import video_stream_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_sop,
    input  logic              push_eop,
    input  logic              ready_in,
    output logic              load_en,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              sop_q,   sop_d;
    logic              eop_q,   eop_d;

    assign load_en = !valid_q || ready_in;

    // Next output beat: hold while stalled, otherwise load or go empty.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave
        // one unassigned and infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (load_en) begin
            valid_d = push;
            if (push) begin
                data_d = push_data;
                sop_d  = push_sop;
                eop_d  = push_eop;
            end
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset too, because data_out is a
        // visible port with a defined reset value (unlike a RAM payload).
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops sample the same
            // pre-edge values regardless of statement order.
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign valid_out         = valid_q;
    assign data_out          = data_q;
    assign startofpacket_out = sop_q;
    assign endofpacket_out   = eop_q;

endmodule

// File: rtl/video_stream_mux.sv
// Two-input Avalon-ST video source selector (camera = sink 0, SD card =
// sink 1). The source is locked for a whole frame and only re-selected
// between frames; beats arriving outside a frame without sop are dropped
// so the output always starts on a frame boundary.
// Optional build macro VIDEO_MUX_DRAIN_UNSELECTED_EN: when defined, the
// unselected sink is always ready and its beats are discarded; otherwise
// the unselected sink sees ready=0.
module video_stream_mux
    import video_stream_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel_req,
    input  logic              valid_in0,
    output logic              ready_out0,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              startofpacket_in0,
    input  logic              endofpacket_in0,
    input  logic              valid_in1,
    output logic              ready_out1,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              startofpacket_in1,
    input  logic              endofpacket_in1,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic              active_sel
);

`ifdef VIDEO_MUX_DRAIN_UNSELECTED_EN
    localparam logic UNSEL_READY = 1'b1;
`else
    localparam logic UNSEL_READY = 1'b0;
`endif

    mux_state_t        state_q, state_d;
    logic              active_sel_q, active_sel_d;

    logic              load_en;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_sop;
    logic              sel_eop;
    logic              accept;
    logic              beat_fwd;

    // The locked sink follows the output register; the other sink is
    // either stalled or drained.
    assign ready_out0 = (active_sel_q == SEL_CAMERA) ? load_en : UNSEL_READY;
    assign ready_out1 = (active_sel_q == SEL_SDCARD) ? load_en : UNSEL_READY;

    // Route the locked sink's beat toward the output stage.
    always_comb begin
        sel_valid = valid_in0;
        sel_data  = data_in0;
        sel_sop   = startofpacket_in0;
        sel_eop   = endofpacket_in0;
        if (active_sel_q == SEL_SDCARD) begin
            sel_valid = valid_in1;
            sel_data  = data_in1;
            sel_sop   = startofpacket_in1;
            sel_eop   = endofpacket_in1;
        end
    end

    assign accept = sel_valid && load_en;

    // Frame-lock FSM: decide forwarding and when the selection may move.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        beat_fwd     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && sel_sop) begin
                    beat_fwd = 1'b1;
                    if (!sel_eop) begin
                        state_d = ST_IN_FRAME;
                    end
                end
                // Follow sel_req between frames, but keep the source a new
                // frame has just opened on so the frame stays single-source.
                if (state_d == ST_IDLE) begin
                    active_sel_d = sel_req;
                end
            end
            ST_IN_FRAME: begin
                if (accept) begin
                    beat_fwd = 1'b1;
                    if (sel_eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and selection registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            active_sel_q <= SEL_CAMERA;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
        end
    end

    video_st_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk               (clk),
        .reset             (reset),
        .push              (beat_fwd),
        .push_data         (sel_data),
        .push_sop          (sel_sop),
        .push_eop          (sel_eop),
        .ready_in          (ready_in),
        .load_en           (load_en),
        .valid_out         (valid_out),
        .data_out          (data_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out)
    );

    assign active_sel = active_sel_q;

endmodule

// File: tb/tb_video_stream_mux.sv
// Scoreboard bench for video_stream_mux: sources are queues of beats, a
// frame-level reference model predicts readies, selection and forwarded
// beats, and a monitor checks every output handshake against the queue.
module tb_video_stream_mux;

    localparam int DATA_W = 16;
`ifdef VIDEO_MUX_DRAIN_UNSELECTED_EN
    localparam bit DRAIN = 1'b1;
`else
    localparam bit DRAIN = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              sel_req;
    logic              valid_in0, ready_out0, startofpacket_in0, endofpacket_in0;
    logic              valid_in1, ready_out1, startofpacket_in1, endofpacket_in1;
    logic [DATA_W-1:0] data_in0, data_in1, data_out;
    logic              valid_out, ready_in, startofpacket_out, endofpacket_out;
    logic              active_sel;

    video_stream_mux #(.DATA_W(DATA_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .sel_req           (sel_req),
        .valid_in0         (valid_in0),
        .ready_out0        (ready_out0),
        .data_in0          (data_in0),
        .startofpacket_in0 (startofpacket_in0),
        .endofpacket_in0   (endofpacket_in0),
        .valid_in1         (valid_in1),
        .ready_out1        (ready_out1),
        .data_in1          (data_in1),
        .startofpacket_in1 (startofpacket_in1),
        .endofpacket_in1   (endofpacket_in1),
        .valid_out         (valid_out),
        .ready_in          (ready_in),
        .data_out          (data_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .active_sel        (active_sel)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t src_q0[$];
    beat_t src_q1[$];
    beat_t sb[$];
    bit    acc0 = 1'b0, acc1 = 1'b0;
    bit    dense = 1'b1;
    int    rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input bit src, input int len, input bit headless,
                              input logic [DATA_W-1:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
            b.sop  = (i == 0) && !headless;
            b.eop  = (i == len - 1);
            if (src) src_q1.push_back(b);
            else     src_q0.push_back(b);
        end
    endtask

    // Upstream sources and downstream ready, driven just after each edge.
    always @(posedge clk) begin
        #1;
        if (acc0 && src_q0.size() > 0) void'(src_q0.pop_front());
        if (acc1 && src_q1.size() > 0) void'(src_q1.pop_front());
        if (!(valid_in0 && !acc0) || src_q0.size() == 0)
            valid_in0 = (src_q0.size() > 0) && (dense || $urandom_range(0, 3) != 0);
        if (!(valid_in1 && !acc1) || src_q1.size() == 0)
            valid_in1 = (src_q1.size() > 0) && (dense || $urandom_range(0, 3) != 0);
        if (src_q0.size() > 0) {data_in0, startofpacket_in0, endofpacket_in0} = src_q0[0];
        if (src_q1.size() > 0) {data_in1, startofpacket_in1, endofpacket_in1} = src_q1[0];
        ready_in = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end

    // Reference model: output slot occupancy, locked source, in-frame flag.
    bit m_ov = 1'b0, m_sel = 1'b0, m_inf = 1'b0;
    always @(negedge clk) begin
        bit    can_take, er0, er1, fwd, nxt;
        beat_t b;
        if (reset) begin
            m_ov = 1'b0; m_sel = 1'b0; m_inf = 1'b0;
            acc0 = 1'b0; acc1 = 1'b0;
            sb.delete();
        end else begin
            can_take = !m_ov || ready_in;
            er0 = (m_sel == 1'b0) ? can_take : DRAIN;
            er1 = (m_sel == 1'b1) ? can_take : DRAIN;
            check("ready_out0", 32'(ready_out0), 32'(er0));
            check("ready_out1", 32'(ready_out1), 32'(er1));
            check("active_sel", 32'(active_sel), 32'(m_sel));
            check("valid_out",  32'(valid_out),  32'(m_ov));
            acc0 = valid_in0 && er0;
            acc1 = valid_in1 && er1;
            fwd  = 1'b0;
            b    = m_sel ? {data_in1, startofpacket_in1, endofpacket_in1}
                         : {data_in0, startofpacket_in0, endofpacket_in0};
            if ((m_sel ? acc1 : acc0) && (m_inf || b.sop)) begin
                fwd = 1'b1;
                sb.push_back(b);
            end
            if (can_take) m_ov = fwd;
            nxt = fwd ? !b.eop : m_inf;
            if (!m_inf && !nxt) m_sel = sel_req;
            m_inf = nxt;
        end
    end

    // Monitor: compare each output handshake and stall stability.
    bit    hold_v = 1'b0;
    beat_t hold_b;
    always @(negedge clk) begin
        beat_t cur;
        cur = {data_out, startofpacket_out, endofpacket_out};
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("stall_hold", 32'(cur), 32'(hold_b));
            if (valid_out && ready_in) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", cur, $time);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if (cur !== e) begin
                        n_errors++;
                        $display("FAIL beat: got %0h expected %0h at %0t", cur, e, $time);
                    end
                end
            end
            hold_v = valid_out && !ready_in;
            hold_b = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait for the sources (one or both) and the scoreboard to empty.
    task automatic wait_idle(input bit cam_only, input string name);
        int cyc = 0;
        while (!(src_q0.size() == 0 && (cam_only || src_q1.size() == 0)
                 && sb.size() == 0 && !valid_out) && cyc < 3000) begin
            tick(1);
            cyc++;
        end
        n_checks++;
        if (cyc >= 3000) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d cycles expected under 3000", name, cyc);
        end
    endtask

    initial begin
        reset = 1'b1; sel_req = 1'b0; ready_in = 1'b0;
        valid_in0 = 1'b0; data_in0 = '0; startofpacket_in0 = 1'b0; endofpacket_in0 = 1'b0;
        valid_in1 = 1'b0; data_in1 = '0; startofpacket_in1 = 1'b0; endofpacket_in1 = 1'b0;
        tick(3);
        check("rst_valid",  32'(valid_out), 32'd0);
        check("rst_data",   32'(data_out), 32'd0);
        check("rst_sop",    32'(startofpacket_out), 32'd0);
        check("rst_eop",    32'(endofpacket_out), 32'd0);
        check("rst_sel",    32'(active_sel), 32'd0);
        reset = 1'b0;

        // Basic 4-beat camera frame.
        push_frame(0, 4, 0, 16'h0001, 0);
        wait_idle(0, "basic");

        // Switch request in the middle of a camera frame.
        push_frame(0, 4, 0, 16'h0010, 0);
        push_frame(1, 3, 0, 16'hF800, 0);
        tick(2);
        sel_req = 1'b1;
        wait_idle(0, "midswitch");

        // Headless beats after reset are dropped, then a real frame passes.
        sel_req = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        push_frame(0, 3, 1, 16'h0005, 0);
        push_frame(0, 3, 0, 16'h0100, 0);
        wait_idle(0, "resync");

        // Downstream stall for three cycles mid-frame.
        push_frame(0, 8, 0, 16'h0200, 0);
        tick(3);
        rdy_mode = 2;
        tick(3);
        rdy_mode = 1;
        wait_idle(0, "stall");

        // Single-beat frame followed by a selection toggle.
        push_frame(0, 1, 0, 16'h07E0, 0);
        push_frame(1, 2, 0, 16'h0300, 0);
        tick(1);
        sel_req = 1'b1;
        wait_idle(0, "single");

        // Unselected sink either drained or stalled while camera streams.
        sel_req = 1'b0;
        tick(2);
        push_frame(0, 6, 0, 16'h0400, 0);
        push_frame(1, 6, 0, 16'h0500, 0);
        tick(10);
        check("sd_backlog", 32'(src_q1.size()), DRAIN ? 32'd0 : 32'd6);
        sel_req = 1'b1;
        wait_idle(0, "drain");

        // Randomised traffic with stalls, gaps, toggles and a mid-run reset.
        dense = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (src_q0.size() < 4)
                push_frame(0, $urandom_range(1, 5), $urandom_range(0, 7) == 0, '0, 1);
            if (src_q1.size() < 4)
                push_frame(1, $urandom_range(1, 5), $urandom_range(0, 7) == 0, '0, 1);
            if ($urandom_range(0, 39) == 0) sel_req = ~sel_req;
            reset = (i == 700);
            tick(1);
        end
        reset = 1'b0;
        sel_req = 1'b0;
        wait_idle(1, "final_cam");
        sel_req = 1'b1;
        wait_idle(0, "final_sd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
